// File: rtl/lsu_bridge.sv
// Load/store bridge: one request at a time, routed to data RAM or a handshaked MMIO port.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests return an error instead of being aligned down.
module lsu_bridge #(
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
  parameter int          MMIO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_access,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ram_load,
  output logic        ram_store,
  output logic [2:0]  ram_access,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out,
  output logic        mmio_valid,
  output logic        mmio_we,
  output logic [2:0]  mmio_access,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_MMIO, S_RESP} state_t;

  // Counter value in the last MMIO cycle allowed before the timeout fires.
  localparam logic [7:0] LP_CNT_LAST = 8'(MMIO_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_mmio_valid;
  logic        r_mmio_we;
  logic [2:0]  r_mmio_access;
  logic [31:0] r_mmio_addr;
  logic [31:0] r_mmio_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic        w_accept;
  logic        w_illegal;
  logic        w_none;
  logic        w_trap;
  logic        w_go;
  logic        w_is_mmio;
  logic [31:0] w_addr_fwd;
  logic [15:0] w_sh;
  logic [31:0] w_ld_ext;

  assign w_accept  = (r_state == S_IDLE) && !rst && req_valid;
  assign w_illegal = (req_access == 3'b011) || (req_access[2:1] == 2'b11)
                     || (req_store && req_access[2]) || (req_load && req_store);
  assign w_none    = !req_load && !req_store;
  assign w_is_mmio = (req_addr >= MMIO_BASE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap     = ((req_access[1:0] == 2'b01) && req_addr[0])
                      || ((req_access[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_addr_fwd = req_addr;
`else
  assign w_trap = 1'b0;
  always_comb begin
    w_addr_fwd = req_addr;
    case (req_access[1:0])
      2'b01:   w_addr_fwd[0]   = 1'b0;
      2'b10:   w_addr_fwd[1:0] = 2'b00;
      default: ;
    endcase
  end
`endif

  assign w_go = w_accept && !w_illegal && !w_none && !w_trap;

  assign req_ready   = (r_state == S_IDLE) && !rst;
  assign ram_load    = w_go && !w_is_mmio && req_load;
  assign ram_store   = w_go && !w_is_mmio && req_store;
  assign ram_access  = req_access;
  assign ram_addr    = w_addr_fwd;
  assign ram_data_in = req_wdata;

  assign mmio_valid  = r_mmio_valid;
  assign mmio_we     = r_mmio_we;
  assign mmio_access = r_mmio_access;
  assign mmio_addr   = r_mmio_addr;
  assign mmio_wdata  = r_mmio_wdata;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_err    = r_resp_err;

  // MMIO returns the raw word; pick the lane by the stored (aligned) address.
  always_comb begin
    w_sh = 16'(mmio_rdata >> {r_mmio_addr[1:0], 3'b000});
    case (r_mmio_access)
      3'b000:  w_ld_ext = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100:  w_ld_ext = {24'h0, w_sh[7:0]};
      3'b001:  w_ld_ext = {{16{w_sh[15]}}, w_sh};
      3'b101:  w_ld_ext = {16'h0, w_sh};
      default: w_ld_ext = mmio_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'h00;
      r_mmio_valid  <= 1'b0;
      r_mmio_we     <= 1'b0;
      r_mmio_access <= 3'b000;
      r_mmio_addr   <= 32'h0;
      r_mmio_wdata  <= 32'h0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= 32'h0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_illegal || w_trap) begin
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'h0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (w_none) begin
              r_resp_err   <= 1'b0;
              r_resp_data  <= 32'h0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (w_is_mmio) begin
              r_mmio_addr   <= w_addr_fwd;
              r_mmio_access <= req_access;
              r_mmio_wdata  <= req_wdata;
              r_mmio_we     <= req_store;
              r_mmio_valid  <= 1'b1;
              r_cnt         <= 8'h00;
              r_state       <= S_MMIO;
            end else begin
              r_resp_err   <= 1'b0;
              r_resp_data  <= req_load ? ram_data_out : 32'h0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end
        S_MMIO: begin
          if (mmio_ack) begin
            r_mmio_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= r_mmio_we ? 32'h0 : w_ld_ext;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_mmio_valid <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_data  <= 32'h0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'h01;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bridge.sv
// Self-checking bench for lsu_bridge: directed scenarios plus a randomized run against a reference model.
// Honors LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_bridge;

  localparam int TIMEOUT = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_access = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        ram_load;
  logic        ram_store;
  logic [2:0]  ram_access;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
  logic        mmio_valid;
  logic        mmio_we;
  logic [2:0]  mmio_access;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_ack = 1'b0;
  logic [31:0] mmio_rdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_bridge #(.MMIO_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_access(req_access), .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .mmio_valid(mmio_valid), .mmio_we(mmio_we), .mmio_access(mmio_access), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] acc);
    case (acc)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Data RAM environment: 256 bytes, little-endian, combinational extended read, posedge write.
  logic [7:0]  ram     [256] = '{default: 8'h00};
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  logic [7:0]  wa;
  logic [31:0] ram_raw;
  assign wa = ram_addr[7:0];

  always_comb begin
    ram_raw      = {ram[wa + 8'd3], ram[wa + 8'd2], ram[wa + 8'd1], ram[wa]};
    ram_data_out = ext(ram_raw, ram_access);
  end

  always @(posedge clk) begin
    if (ram_store) begin
      case (ram_access[1:0])
        2'b00: ram[wa] <= ram_data_in[7:0];
        2'b01: begin
          ram[wa]        <= ram_data_in[7:0];
          ram[wa + 8'd1] <= ram_data_in[15:8];
        end
        default: begin
          ram[wa]        <= ram_data_in[7:0];
          ram[wa + 8'd1] <= ram_data_in[15:8];
          ram[wa + 8'd2] <= ram_data_in[23:16];
          ram[wa + 8'd3] <= ram_data_in[31:24];
        end
      endcase
    end
  end

  typedef struct {
    bit          err;
    bit          go;
    bit          mmio;
    logic [31:0] eff;
    int          size;
  } pred_t;

  function automatic pred_t predict(input bit ld, input bit st, input logic [2:0] acc,
                                    input logic [31:0] addr);
    pred_t       p;
    logic [31:0] msk;
    bit          illegal;
    bit          mis;
    p.size  = 1 << acc[1:0];
    msk     = 32'(p.size - 1);
    illegal = (acc == 3'd3) || (acc == 3'd6) || (acc == 3'd7) || (st && acc >= 3'd4) || (ld && st);
    mis     = (addr & msk) != 0;
    p.err = 1'b0; p.go = 1'b0; p.mmio = 1'b0; p.eff = addr;
    if (illegal || (ld || st) && TRAP && mis) p.err = 1'b1;
    else if (ld || st) begin
      p.go   = 1'b1;
      p.mmio = addr >= 32'h8000_0000;
      p.eff  = addr & ~msk;
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] last_data;

  // One complete request: accept, optional MMIO phase, response, return to IDLE.
  task automatic run_req(input string tag, input bit ld, input bit st, input logic [2:0] acc,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_delay, input logic [31:0] rdata);
    pred_t       p;
    logic [31:0] exp_data;
    logic [31:0] raw;
    bit          exp_err;
    bit          acked;
    bit          got;
    int          n_mv;
    int          n_rdy;
    p = predict(ld, st, acc, addr);
    exp_data = 32'h0;
    exp_err  = p.err;
    @(posedge clk); #1;
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_access = acc; req_addr = addr; req_wdata = wdata;
    #1;
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    chk({tag, ":ram_load"}, 32'(ram_load), 32'(p.go && !p.mmio && ld));
    chk({tag, ":ram_store"}, 32'(ram_store), 32'(p.go && !p.mmio && st));
    if (p.go && !p.mmio) begin
      chk({tag, ":ram_addr"}, ram_addr, p.eff);
      for (int k = 0; k < 4; k++) raw[8*k +: 8] = ref_mem[8'(p.eff[7:0] + 8'(k))];
      if (ld) exp_data = ext(raw, acc);
      if (st) for (int k = 0; k < p.size; k++) ref_mem[8'(p.eff[7:0] + 8'(k))] = wdata[8*k +: 8];
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    if (p.go && p.mmio) begin
      chk({tag, ":mmio_valid"}, 32'(mmio_valid), 32'd1);
      chk({tag, ":mmio_addr"}, mmio_addr, p.eff);
      chk({tag, ":mmio_we"}, 32'(mmio_we), 32'(st));
      chk({tag, ":mmio_access"}, 32'(mmio_access), 32'(acc));
      chk({tag, ":mmio_wdata"}, mmio_wdata, wdata);
      n_mv = 0; n_rdy = 0; got = 1'b0;
      for (int c = 0; c < TIMEOUT + 4; c++) begin
        if (resp_valid) begin got = 1'b1; break; end
        if (mmio_valid) n_mv++;
        if (req_ready) n_rdy++;
        mmio_ack   = (c + 1 == ack_delay);
        mmio_rdata = rdata;
        @(posedge clk); #1;
        mmio_ack = 1'b0;
      end
      acked = (ack_delay >= 1) && (ack_delay <= TIMEOUT);
      chk({tag, ":resp_seen"}, 32'(got), 32'd1);
      chk({tag, ":mmio_cycles"}, 32'(n_mv), acked ? 32'(ack_delay) : 32'(TIMEOUT));
      chk({tag, ":ready_in_mmio"}, 32'(n_rdy), 32'd0);
      if (acked && ld) exp_data = ext(rdata >> {p.eff[1:0], 3'b000}, acc);
      exp_err = !acked;
    end
    chk({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ":resp_data"}, resp_data, exp_data);
    chk({tag, ":resp_err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, ":mmio_idle"}, 32'(mmio_valid), 32'd0);
    last_data = resp_data;
    @(posedge clk); #1;
    chk({tag, ":resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, ":ready_after"}, 32'(req_ready), 32'd1);
  endtask

  logic [2:0] acc_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  initial begin
    logic [31:0] saved;
    int          n;
    int          sel;
    bit          ld, st;
    logic [2:0]  acc;
    logic [31:0] addr;

    // Reset with a pending load: nothing may reach the RAM.
    req_valid = 1'b1; req_load = 1'b1; req_access = 3'b010; req_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:req_ready", 32'(req_ready), 32'd0);
    chk("rst:ram_load", 32'(ram_load), 32'd0);
    chk("rst:ram_store", 32'(ram_store), 32'd0);
    chk("rst:mmio_valid", 32'(mmio_valid), 32'd0);
    chk("rst:mmio_we", 32'(mmio_we), 32'd0);
    chk("rst:mmio_access", 32'(mmio_access), 32'd0);
    chk("rst:mmio_addr", mmio_addr, 32'd0);
    chk("rst:mmio_wdata", mmio_wdata, 32'd0);
    chk("rst:resp_valid", 32'(resp_valid), 32'd0);
    chk("rst:resp_data", resp_data, 32'd0);
    chk("rst:resp_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0; req_load = 1'b0;
    rst = 1'b0;

    run_req("sw_10", 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0);
    run_req("lb_13", 1, 0, 3'b000, 32'h13, 0, 0, 0);
    chk("lb_13:value", last_data, 32'hFFFF_FFDE);
    run_req("lbu_13", 1, 0, 3'b100, 32'h13, 0, 0, 0);
    chk("lbu_13:value", last_data, 32'h0000_00DE);
    run_req("lh_10", 1, 0, 3'b001, 32'h10, 0, 0, 0);
    saved = last_data;
    run_req("lh_11", 1, 0, 3'b001, 32'h11, 0, 0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lh_11:eq_lh_10", last_data, saved);
`endif

    run_req("mmio_lhu", 1, 0, 3'b101, 32'h8000_0002, 0, 3, 32'h8001_1234);
    chk("mmio_lhu:value", last_data, 32'h0000_8001);

    run_req("mmio_sw_to", 0, 1, 3'b010, 32'h8000_0000, 32'h1234_5678, 0, 0);
    mmio_ack = 1'b1;
    @(posedge clk); #1;
    mmio_ack = 1'b0;
    n = 0;
    repeat (3) begin
      if (resp_valid) n++;
      @(posedge clk); #1;
    end
    chk("stray_ack:resp", 32'(n), 32'd0);

    // Reset while an MMIO request is outstanding.
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b1; req_access = 3'b010;
    req_addr = 32'h8000_0010; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0;
    chk("rstmid:mmio_valid_before", 32'(mmio_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid:mmio_valid", 32'(mmio_valid), 32'd0);
    chk("rstmid:resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid:ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid:ready_after", 32'(req_ready), 32'd1);
    mmio_ack = 1'b1;
    @(posedge clk); #1;
    mmio_ack = 1'b0;
    n = 0;
    repeat (3) begin
      if (resp_valid) n++;
      @(posedge clk); #1;
    end
    chk("rstmid:late_ack", 32'(n), 32'd0);

    run_req("ill_011", 1, 0, 3'b011, 32'h10, 0, 0, 0);
    run_req("ill_ldst", 1, 1, 3'b010, 32'h10, 32'h0BAD_0BAD, 0, 0);
    run_req("ill_sbu", 0, 1, 3'b100, 32'h10, 32'h0000_0055, 0, 0);
    chk("ill:ram_word", {ram[8'h13], ram[8'h12], ram[8'h11], ram[8'h10]}, 32'hDEAD_BEEF);
    run_req("none", 0, 0, 3'b010, 32'h20, 32'h7777_7777, 0, 0);
    run_req("lw_below_base", 1, 0, 3'b010, 32'h7FFF_FFFC, 0, 0, 0);
    run_req("mmio_lb", 1, 0, 3'b000, 32'h8000_0003, 0, 4, 32'h9A00_0000);
    chk("mmio_lb:value", last_data, 32'hFFFF_FF9A);

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      acc = acc_tab[$urandom_range(0, 7)];
      ld  = (sel <= 4);
      st  = (sel >= 5 && sel <= 8);
      if (sel == 9) begin
        ld = 1'($urandom_range(0, 1));
        st = ld;
        if (!ld) acc = 3'b010;
      end
      addr = $urandom_range(0, 1) ? 32'h8000_0000 + 32'($urandom_range(0, 255))
                                  : 32'($urandom_range(0, 255));
      if (!ld && !st) addr = addr & ~32'h3;
      run_req("rand", ld, st, acc, addr, $urandom, int'($urandom_range(0, 6)), $urandom);
    end

    n = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) n++;
    chk("final:ram_image", 32'(n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
